clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl_if.sv | 27 ++
 rtl/clock_set_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Key/tick inputs and BCD time display outputs of the clock setting controller.
// The master side drives keys and ticks; the slave side is the controller.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [1:0] hour_t;
  logic [3:0] hour_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] mode;
  logic [5:0] blank;
  logic       carry_day;

  modport master (
    output tick_1hz, key_mode, key_inc, key_dec,
    input  hour_t, hour_u, min_t, min_u, sec_t, sec_u, mode, blank, carry_day
  );

  modport slave (
    input  tick_1hz, key_mode, key_inc, key_dec,
    output hour_t, hour_u, min_t, min_u, sec_t, sec_u, mode, blank, carry_day
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-of-day keeper with RUN/SET_H/SET_M/SET_S modes, per-field BCD editing
// and a blinking blank mask on the field being edited.
module clock_set_ctrl #(
  parameter int HOUR_MAX  = 23,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  clock_set_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } mode_e;

  localparam int         CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [1:0] HMAX_T   = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HMAX_U   = 4'(HOUR_MAX % 10);

  // Units digit of a BCD field stepped by one; at_end means the field sits at
  // its wrap point for the chosen direction (max when up, zero when down).
  function automatic logic [3:0] units_step(input logic [3:0] u, input logic [3:0] max_u,
                                            input logic at_end, input logic up);
    if (up)
      return (at_end || u == 4'd9) ? 4'd0 : u + 4'd1;
    else
      return at_end ? max_u : ((u == 4'd0) ? 4'd9 : u - 4'd1);
  endfunction

  function automatic logic [2:0] tens_step(input logic [2:0] t, input logic [3:0] u,
                                           input logic [2:0] max_t, input logic at_end,
                                           input logic up);
    if (up)
      return at_end ? 3'd0 : ((u == 4'd9) ? t + 3'd1 : t);
    else
      return at_end ? max_t : ((u == 4'd0) ? t - 3'd1 : t);
  endfunction

  mode_e            mode_q, mode_d;
  logic [1:0]       hour_t_q, hour_t_d;
  logic [3:0]       hour_u_q, hour_u_d;
  logic [2:0]       min_t_q, min_t_d;
  logic [3:0]       min_u_q, min_u_d;
  logic [2:0]       sec_t_q, sec_t_d;
  logic [3:0]       sec_u_q, sec_u_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [5:0]       blank_q, blank_d;
  logic             carry_day_q, carry_day_d;

  logic hour_max, min_max, sec_max;
  logic hour_zero, min_zero, sec_zero;
  logic tick_run, key_edit;

  assign hour_max  = (hour_t_q == HMAX_T) && (hour_u_q == HMAX_U);
  assign min_max   = (min_t_q == 3'd5) && (min_u_q == 4'd9);
  assign sec_max   = (sec_t_q == 3'd5) && (sec_u_q == 4'd9);
  assign hour_zero = (hour_t_q == 2'd0) && (hour_u_q == 4'd0);
  assign min_zero  = (min_t_q == 3'd0) && (min_u_q == 4'd0);
  assign sec_zero  = (sec_t_q == 3'd0) && (sec_u_q == 4'd0);

  // A mode press wins over a simultaneous inc/dec; inc+dec together cancel.
  assign tick_run = (mode_q == RUN) && bus.tick_1hz;
  assign key_edit = (mode_q != RUN) && !bus.key_mode && (bus.key_inc ^ bus.key_dec);

  always_comb begin
    mode_d        = mode_q;
    hour_t_d      = hour_t_q;
    hour_u_d      = hour_u_q;
    min_t_d       = min_t_q;
    min_u_d       = min_u_q;
    sec_t_d       = sec_t_q;
    sec_u_d       = sec_u_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    blank_d       = 6'b000000;
    carry_day_d   = 1'b0;

    if (tick_run) begin
      sec_u_d = units_step(sec_u_q, 4'd9, sec_max, 1'b1);
      sec_t_d = tens_step(sec_t_q, sec_u_q, 3'd5, sec_max, 1'b1);
      if (sec_max) begin
        min_u_d = units_step(min_u_q, 4'd9, min_max, 1'b1);
        min_t_d = tens_step(min_t_q, min_u_q, 3'd5, min_max, 1'b1);
        if (min_max) begin
          hour_u_d = units_step(hour_u_q, HMAX_U, hour_max, 1'b1);
          hour_t_d = 2'(tens_step({1'b0, hour_t_q}, hour_u_q, {1'b0, HMAX_T}, hour_max, 1'b1));
          carry_day_d = hour_max;
        end
      end
    end

    if (key_edit) begin
      unique case (mode_q)
        SET_H: begin
          hour_u_d = units_step(hour_u_q, HMAX_U, bus.key_inc ? hour_max : hour_zero, bus.key_inc);
          hour_t_d = 2'(tens_step({1'b0, hour_t_q}, hour_u_q, {1'b0, HMAX_T},
                                  bus.key_inc ? hour_max : hour_zero, bus.key_inc));
        end
        SET_M: begin
          min_u_d = units_step(min_u_q, 4'd9, bus.key_inc ? min_max : min_zero, bus.key_inc);
          min_t_d = tens_step(min_t_q, min_u_q, 3'd5, bus.key_inc ? min_max : min_zero, bus.key_inc);
        end
        SET_S: begin
          sec_u_d = units_step(sec_u_q, 4'd9, bus.key_inc ? sec_max : sec_zero, bus.key_inc);
          sec_t_d = tens_step(sec_t_q, sec_u_q, 3'd5, bus.key_inc ? sec_max : sec_zero, bus.key_inc);
        end
        default: ;
      endcase
    end

    if (bus.key_mode) begin
      unique case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        default: mode_d = RUN;
      endcase
    end

    // Restarting the blink on every edit keeps the field visible right away.
    if (bus.key_mode || key_edit) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (mode_q != RUN) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end

    unique case (mode_d)
      SET_H:   blank_d = {{2{blink_phase_d}}, 4'b0000};
      SET_M:   blank_d = {2'b00, {2{blink_phase_d}}, 2'b00};
      SET_S:   blank_d = {4'b0000, {2{blink_phase_d}}};
      default: blank_d = 6'b000000;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q        <= RUN;
      hour_t_q      <= '0;
      hour_u_q      <= '0;
      min_t_q       <= '0;
      min_u_q       <= '0;
      sec_t_q       <= '0;
      sec_u_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      blank_q       <= '0;
      carry_day_q   <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      hour_t_q      <= hour_t_d;
      hour_u_q      <= hour_u_d;
      min_t_q       <= min_t_d;
      min_u_q       <= min_u_d;
      sec_t_q       <= sec_t_d;
      sec_u_q       <= sec_u_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      blank_q       <= blank_d;
      carry_day_q   <= carry_day_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.hour_t    = hour_t_q;
  assign bus.hour_u    = hour_u_q;
  assign bus.min_t     = min_t_q;
  assign bus.min_u     = min_u_q;
  assign bus.sec_t     = sec_t_q;
  assign bus.sec_u     = sec_u_q;
  assign bus.blank     = blank_q;
  assign bus.carry_day = carry_day_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed table, corner sequences and random
// stimulus, all checked against a seconds-based reference model.
module tb_clock_set_ctrl;
  localparam int HOUR_MAX  = 23;
  localparam int BLINK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.HOUR_MAX(HOUR_MAX), .BLINK_DIV(BLINK_DIV)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers for time, mode index and cycles since the
  // last blink restart.
  int   m_h, m_m, m_s, m_mode, m_since;
  logic m_carry;

  function automatic logic [28:0] make_vec(input int mode, input int h, input int m,
                                           input int s, input logic [5:0] blank,
                                           input logic carry);
    return {2'(mode), 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), blank, carry};
  endfunction

  function automatic logic [28:0] model_vec();
    logic [5:0] b;
    b = 6'b000000;
    if (m_mode != 0 && ((m_since / BLINK_DIV) % 2) == 1)
      b = 6'b000011 << (2 * (3 - m_mode));
    return make_vec(m_mode, m_h, m_m, m_s, b, m_carry);
  endfunction

  function automatic logic [28:0] dut_vec();
    return {bus.mode, bus.hour_t, bus.hour_u, bus.min_t, bus.min_u,
            bus.sec_t, bus.sec_u, bus.blank, bus.carry_day};
  endfunction

  task automatic check(input string name, input logic [28:0] got, input logic [28:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got mode=%b time=%h blank=%b carry=%b, expected mode=%b time=%h blank=%b carry=%b",
               name, got[28:27], got[26:7], got[6:1], got[0],
               exp[28:27], exp[26:7], exp[6:1], exp[0]);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit km, input bit ki, input bit kd);
    int secs, old_mode, delta;
    bit acc;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_since = 0; m_carry = 1'b0;
      return;
    end
    m_carry  = 1'b0;
    old_mode = m_mode;
    if (old_mode == 0 && t) begin
      secs = m_h * 3600 + m_m * 60 + m_s + 1;
      if (secs == (HOUR_MAX + 1) * 3600) begin
        secs = 0;
        m_carry = 1'b1;
      end
      m_h = secs / 3600;
      m_m = (secs / 60) % 60;
      m_s = secs % 60;
    end
    acc   = (old_mode != 0) && !km && (ki != kd);
    delta = ki ? 1 : -1;
    if (acc) begin
      case (old_mode)
        1: m_h = (m_h + delta + HOUR_MAX + 1) % (HOUR_MAX + 1);
        2: m_m = (m_m + delta + 60) % 60;
        default: m_s = (m_s + delta + 60) % 60;
      endcase
    end
    if (km) m_mode = (old_mode + 1) % 4;
    if (km || acc) m_since = 0;
    else if (old_mode != 0) m_since++;
  endtask

  task automatic cyc(input bit r, input bit t, input bit km, input bit ki, input bit kd);
    rst          = r;
    bus.tick_1hz = t;
    bus.key_mode = km;
    bus.key_inc  = ki;
    bus.key_dec  = kd;
    @(posedge clk);
    model_step(r, t, km, ki, kd);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit         tick, km, ki, kd;
    int         mode, h, m, s;
    logic [5:0] blank;
  } vec_t;

  vec_t tbl[16];
  bit   any_carry;
  bit   r_r, r_t, r_km, r_ki, r_kd;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 6'b0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 2, 6'b0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 2, 6'b0};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0, 2, 6'b0};
    tbl[4]  = '{0, 0, 1, 0, 1, 1, 0, 2, 6'b0};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 2, 6'b0};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 0, 2, 6'b0};
    tbl[7]  = '{0, 0, 0, 1, 1, 23, 0, 2, 6'b0};
    tbl[8]  = '{0, 1, 1, 0, 2, 23, 0, 2, 6'b0};
    tbl[9]  = '{0, 0, 0, 1, 2, 23, 59, 2, 6'b0};
    tbl[10] = '{0, 0, 1, 0, 2, 23, 0, 2, 6'b0};
    tbl[11] = '{0, 0, 1, 1, 2, 23, 0, 2, 6'b0};
    tbl[12] = '{0, 1, 0, 0, 3, 23, 0, 2, 6'b0};
    tbl[13] = '{0, 0, 1, 0, 3, 23, 0, 3, 6'b0};
    tbl[14] = '{1, 1, 0, 0, 0, 23, 0, 3, 6'b0};
    tbl[15] = '{1, 1, 0, 0, 1, 23, 0, 4, 6'b0};

    bus.tick_1hz = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0; bus.key_dec = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    check("reset_state", dut_vec(), make_vec(0, 0, 0, 0, 6'b0, 1'b0));

    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, tbl[i].tick, tbl[i].km, tbl[i].ki, tbl[i].kd);
      check($sformatf("table[%0d]", i), dut_vec(),
            make_vec(tbl[i].mode, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].blank, 1'b0));
    end

    // 3661 ticks from reset.
    cyc(1, 0, 0, 0, 0);
    any_carry = 1'b0;
    for (int i = 0; i < 3661; i++) begin
      cyc(0, 1, 0, 0, 0);
      any_carry |= bus.carry_day;
    end
    check("cascade_3661", dut_vec(), make_vec(0, 1, 1, 1, 6'b0, 1'b0));
    check("cascade_no_carry", {28'b0, any_carry}, 29'b0);

    // Day wrap from 23:59:59 set by decrementing each field from zero.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    check("set_235959", dut_vec(), make_vec(0, 23, 59, 59, 6'b0, 1'b0));
    cyc(0, 1, 0, 0, 0);
    check("day_wrap", dut_vec(), make_vec(0, 0, 0, 0, 6'b0, 1'b1));
    cyc(0, 0, 0, 0, 0);
    check("carry_one_cycle", dut_vec(), make_vec(0, 0, 0, 0, 6'b0, 1'b0));

    // Hours 23 -> 00 on increment.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    check("hour_inc_wrap", dut_vec(), make_vec(1, 0, 0, 0, 6'b0, 1'b0));

    // Freeze in SET_S.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    check("freeze", dut_vec(), make_vec(3, 0, 0, 5, 6'b0, 1'b0));
    cyc(0, 0, 0, 1, 1);
    check("inc_dec_cancel", dut_vec(), make_vec(3, 0, 0, 5, 6'b0, 1'b0));
    cyc(0, 0, 1, 1, 0);
    check("mode_beats_inc", dut_vec(), make_vec(0, 0, 0, 5, 6'b0, 1'b0));

    // Blink in SET_H, then restart on an increment.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 0);
      check($sformatf("blink_h[%0d]", k), {23'b0, bus.blank},
            {23'b0, (((k / 4) % 2) == 1) ? 6'b110000 : 6'b000000});
    end
    cyc(0, 0, 0, 1, 0);
    check("blink_restart[0]", {23'b0, bus.blank}, 29'b0);
    for (int k = 1; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0);
      check($sformatf("blink_restart[%0d]", k), {23'b0, bus.blank}, 29'b0);
    end
    cyc(0, 0, 0, 0, 0);
    check("blink_resume", dut_vec(), make_vec(1, 1, 0, 0, 6'b110000, 1'b0));

    // Reset during SET_M with blank active and a coincident tick.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    check("blink_m_active", dut_vec(), make_vec(2, 0, 0, 3, 6'b001100, 1'b0));
    cyc(1, 1, 0, 0, 0);
    check("reset_mid_set", dut_vec(), make_vec(0, 0, 0, 0, 6'b0, 1'b0));

    // Random stimulus against the model.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(299) == 0);
      r_t  = ($urandom_range(2) == 0);
      r_km = ($urandom_range(9) == 0);
      r_ki = ($urandom_range(4) == 0);
      r_kd = ($urandom_range(4) == 0);
      cyc(r_r, r_t, r_km, r_ki, r_kd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
